// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous modulo-MOD counter with up, down, bounce and hold modes,
// parallel load (clamped to MOD-1), count enable, terminal-count level and wrap pulse.
// Optional build macro COUNTER_SATURATE_EN: modes 00/01 saturate at the ends instead of wrapping.
module updown_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             wrap
);

  if (MOD < 2 || 64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("updown_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  // One bit of headroom so MOD-1 and the +1/-1 steps never alias when MOD == 2**WIDTH.
  localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);

  logic [WIDTH:0]   cnt_w;
  logic [WIDTH:0]   lv_w;
  logic [WIDTH:0]   nxt_w;
  logic [WIDTH-1:0] count_d;
  logic             dir_d;
  logic             tc_d;
  logic             wrap_d;

  assign cnt_w = {1'b0, count};
  assign lv_w  = {1'b0, load_val};

  // Next count, direction and wrap pulse; load takes priority over a step.
  always_comb begin
    nxt_w  = cnt_w;
    dir_d  = dir;
    wrap_d = 1'b0;

    // Fixed-direction modes rewrite dir every edge, even when not stepping.
    if (mode == MODE_UP) begin
      dir_d = 1'b1;
    end else if (mode == MODE_DOWN) begin
      dir_d = 1'b0;
    end

    if (load) begin
      nxt_w = (lv_w > MAX_W) ? MAX_W : lv_w;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (cnt_w == MAX_W) begin
`ifdef COUNTER_SATURATE_EN
            nxt_w = cnt_w;
`else
            nxt_w  = '0;
            wrap_d = 1'b1;
`endif
          end else begin
            nxt_w = cnt_w + ONE_W;
          end
        end
        MODE_DOWN: begin
          if (cnt_w == '0) begin
`ifdef COUNTER_SATURATE_EN
            nxt_w = cnt_w;
`else
            nxt_w  = MAX_W;
            wrap_d = 1'b1;
`endif
          end else begin
            nxt_w = cnt_w - ONE_W;
          end
        end
        MODE_BOUNCE: begin
          if (dir) begin
            if (cnt_w == MAX_W) begin
              nxt_w  = cnt_w - ONE_W;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              nxt_w = cnt_w + ONE_W;
            end
          end else begin
            if (cnt_w == '0) begin
              nxt_w  = ONE_W;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              nxt_w = cnt_w - ONE_W;
            end
          end
        end
        default: begin
          nxt_w = cnt_w;
        end
      endcase
    end

    count_d = nxt_w[WIDTH-1:0];
    // tc is registered, so it is derived from the values about to be stored.
    tc_d    = dir_d ? (nxt_w == MAX_W) : (nxt_w == '0);
  end

  // State update; clear overrides everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      dir   <= 1'b1;
      tc    <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      dir   <= dir_d;
      tc    <= tc_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=4, MOD=10): stimulus pushes model expectations,
// a monitor pops and compares after every rising edge. Honours COUNTER_SATURATE_EN like the DUT.
module tb_updown_mod_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MOD   = 10;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tc;
    logic             wrap;
  } exp_t;

  logic             clk = 1'b0;
  logic             clear;
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             wrap;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference state
  int   m_count = 0;
  bit   m_dir   = 1'b1;

  updown_mod_counter #(
    .WIDTH(WIDTH),
    .MOD  (MOD)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .dir     (dir),
    .tc      (tc),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the outcome of the next edge, then wait for the negedge.
  task automatic step(input bit c, input bit e, input int md, input bit ld, input int lv);
    exp_t x;
    int   nc;
    bit   nd;
    bit   w;
    clear    = c;
    en       = e;
    mode     = 2'(md);
    load     = ld;
    load_val = WIDTH'(lv);
    if (c) begin
      nc = 0;
      nd = 1'b1;
      w  = 1'b0;
    end else begin
      nc = m_count;
      nd = (md == 0) ? 1'b1 : (md == 1) ? 1'b0 : m_dir;
      w  = 1'b0;
      if (ld) begin
        nc = (lv > MOD - 1) ? MOD - 1 : lv;
      end else if (e) begin
        if (md == 0) begin
`ifdef COUNTER_SATURATE_EN
          nc = (m_count + 1 > MOD - 1) ? MOD - 1 : m_count + 1;
`else
          w  = (m_count == MOD - 1);
          nc = (m_count + 1) % MOD;
`endif
        end else if (md == 1) begin
`ifdef COUNTER_SATURATE_EN
          nc = (m_count == 0) ? 0 : m_count - 1;
`else
          w  = (m_count == 0);
          nc = (m_count + MOD - 1) % MOD;
`endif
        end else if (md == 2) begin
          // Ping-pong: reflect off either end.
          if (m_dir && m_count == MOD - 1) begin
            nc = MOD - 2; nd = 1'b0; w = 1'b1;
          end else if (!m_dir && m_count == 0) begin
            nc = 1; nd = 1'b1; w = 1'b1;
          end else begin
            nc = m_dir ? m_count + 1 : m_count - 1;
          end
        end
      end
    end
    m_count = nc;
    m_dir   = nd;
    x.count = WIDTH'(nc);
    x.dir   = nd;
    x.tc    = c ? 1'b0 : (nd ? (nc == MOD - 1) : (nc == 0));
    x.wrap  = w;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: every edge yields one registered result to compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL underflow: DUT output with no expectation queued at %0t", $time);
        end
      end else begin
        x = exp_q.pop_front();
        checks++;
        if ({count, dir, tc, wrap} !== x) begin
          errors++;
          $display("FAIL outputs @%0t: got count=%0d dir=%b tc=%b wrap=%b, want count=%0d dir=%b tc=%b wrap=%b",
                   $time, count, dir, tc, wrap, x.count, x.dir, x.tc, x.wrap);
        end
      end
    end
  end

  initial begin
    int md;
    // Reset, then up count through the wrap
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    // Down from 0
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 1, 0, 0);
    // Bounce from 7 going up
    step(0, 0, 0, 1, 7);
    for (int i = 0; i < 14; i++) step(0, 1, 2, 0, 0);
    // Clamped load beats en; clear beats load
    step(0, 1, 0, 1, 12);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 5);
    // Hold at 4, then clear mid-bounce
    step(0, 0, 0, 1, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2, 0, 0);
    step(1, 1, 2, 0, 0);
    step(0, 0, 3, 0, 0);
    // Up from 7 past the top (wraps or saturates depending on build)
    step(0, 0, 0, 1, 7);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    // Down from 2 past the bottom
    step(0, 0, 1, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    // Randomized traffic, modes held for runs so wraps and bounces are reached
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) md = int'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), md,
           ($urandom_range(0, 24) == 0), int'($urandom_range(0, 15)));
    end
    done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
